tt_um_ddc_arghunter: RTL and testbench

TT_UM_DDC_ARGHUNTER -- requirements
Module: tt_um_ddc_arghunter

---
 rtl/tt_um_ddc_arghunter.sv | 120 ++++++++++++
 tb/tb_tt_um_ddc_arghunter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/tt_um_ddc_arghunter.sv
// Multi-mode code converter: Gray, BCD, priority encode, popcount and 7-segment
// decode of an 8-bit operand, registered with single-cycle latency.
module tt_um_ddc_arghunter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int DATA_W = 8;

  logic [2:0]        mode;
  logic [DATA_W-1:0] res;
  logic              err;
  logic [1:0]        aux;
  logic              unused_bits;

  logic [DATA_W-1:0] res_p0;
  logic              err_p0;
  logic              zero_p0;
  logic [1:0]        aux_p0;

  assign mode        = uio_in[2:0];
  assign unused_bits = &uio_in[7:3];

  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Shift-add-3 conversion; result is {hundreds[1:0], tens[3:0], ones[3:0]}.
  function automatic logic [9:0] bin2bcd(input logic [7:0] v);
    logic [17:0] s;
    s = {10'd0, v};
    for (int i = 0; i < 8; i++) begin
      if (s[11:8]  >= 4'd5) s[11:8]  = s[11:8]  + 4'd3;
      if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
      s = s << 1;
    end
    return s[17:8];
  endfunction

  function automatic logic [2:0] prio_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) idx = i[2:0];
    return idx;
  endfunction

  function automatic logic [3:0] popcnt(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] h);
    logic [7:0] s;
    case (h)
      4'h0: s = 8'h3F;  4'h1: s = 8'h06;  4'h2: s = 8'h5B;  4'h3: s = 8'h4F;
      4'h4: s = 8'h66;  4'h5: s = 8'h6D;  4'h6: s = 8'h7D;  4'h7: s = 8'h07;
      4'h8: s = 8'h7F;  4'h9: s = 8'h6F;  4'hA: s = 8'h77;  4'hB: s = 8'h7C;
      4'hC: s = 8'h39;  4'hD: s = 8'h5E;  4'hE: s = 8'h79;  default: s = 8'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    logic [9:0] bcd;
    res = 8'd0;
    err = 1'b0;
    aux = 2'd0;
    bcd = bin2bcd(ui_in);
    case (mode)
      3'd0: res = ui_in;
      3'd1: res = ui_in ^ (ui_in >> 1);
      3'd2: res = gray2bin(ui_in);
      3'd3: begin
        res = bcd[7:0];
        aux = bcd[9:8];
      end
      3'd4: begin
        if (ui_in[7:4] > 4'd9 || ui_in[3:0] > 4'd9) err = 1'b1;
        else res = {1'b0, ui_in[7:4], 3'd0} + {3'd0, ui_in[7:4], 1'b0} + {4'd0, ui_in[3:0]};
      end
      3'd5: begin
        if (ui_in == 8'd0) err = 1'b1;
        else res = {5'd0, prio_idx(ui_in)};
      end
      3'd6: res = {4'd0, popcnt(ui_in)};
      default: res = seg7(ui_in[3:0]);
    endcase
  end

  // Stage p0: output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_p0  <= '0;
      err_p0  <= 1'b0;
      zero_p0 <= 1'b0;
      aux_p0  <= 2'd0;
    end else if (ena) begin
      res_p0  <= res;
      err_p0  <= err;
      zero_p0 <= (res == 8'd0);
      aux_p0  <= aux;
    end
  end

  assign uo_out  = res_p0;
  assign uio_out = {err_p0, zero_p0, aux_p0, 4'd0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_ddc_arghunter.sv
// Scoreboard bench for the code converter: expected results queued at drive
// time from an independent model, popped and compared one edge later.
module tb_tt_um_ddc_arghunter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] sb[$];
  logic [15:0] last = 16'd0;

  tt_um_ddc_arghunter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Reference model built from arithmetic, not from the gate structure.
  function automatic logic [15:0] model(input int m, input int d);
    int o, e, a, k;
    logic [7:0] segs[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    o = 0; e = 0; a = 0;
    case (m)
      0: o = d;
      1: o = d ^ (d >> 1);
      2: for (k = 0; k < 8; k++) o = o ^ (d >> k);
      3: begin o = ((d / 10) % 10) * 16 + d % 10; a = d / 100; end
      4: if ((d / 16) > 9 || (d % 16) > 9) e = 1; else o = (d / 16) * 10 + d % 16;
      5: if (d == 0) e = 1; else begin k = 7; while (((d >> k) & 1) == 0) k--; o = k; end
      6: o = $countones(d[7:0]);
      default: o = segs[d % 16];
    endcase
    return {e[0], (o[7:0] == 8'd0), a[1:0], 4'd0, o[7:0]};
  endfunction

  task automatic step(input string tag, input int m, input int d, input logic e, input logic r);
    logic [15:0] x;
    @(negedge clk);
    ui_in  = d[7:0];
    uio_in = {$urandom_range(0, 31) % 32 == 0 ? 5'h1F : 5'($urandom), m[2:0]};
    ena    = e;
    rst_n  = r;
    if (!r) last = 16'd0;
    else if (e) last = model(m, d);
    sb.push_back(last);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, ".out"}, uo_out, x[7:0]);
    chk({tag, ".uio"}, uio_out, x[15:8]);
  endtask

  initial begin
    chk("oe_in_reset", uio_oe, 8'hF0);
    step("rst0", 0, 8'h5A, 1'b1, 1'b0);
    step("rst1", 0, 8'h5A, 1'b0, 1'b0);
    chk("rst_oe", uio_oe, 8'hF0);

    step("bcd_ff", 3, 8'hFF, 1'b1, 1'b1);
    chk("bcd_ff_val", uo_out, 8'h55);
    chk("bcd_ff_aux", {6'd0, uio_out[5:4]}, 8'd2);
    step("bcd_00", 3, 8'h00, 1'b1, 1'b1);
    chk("bcd_00_zero", {7'd0, uio_out[6]}, 8'd1);
    step("seg_0a", 7, 8'h0A, 1'b1, 1'b1);
    chk("seg_0a_val", uo_out, 8'h77);
    step("b2g_0b", 1, 8'h0B, 1'b1, 1'b1);
    chk("b2g_0b_val", uo_out, 8'h0E);
    step("g2b_0e", 2, 8'h0E, 1'b1, 1'b1);
    chk("g2b_0e_val", uo_out, 8'h0B);
    step("g2b_80", 2, 8'h80, 1'b1, 1'b1);
    chk("g2b_80_val", uo_out, 8'hFF);
    step("bcd2b_99", 4, 8'h99, 1'b1, 1'b1);
    chk("bcd2b_99_val", uo_out, 8'h63);
    step("bcd2b_9a", 4, 8'h9A, 1'b1, 1'b1);
    chk("bcd2b_9a_uio", uio_out, 8'hC0);
    step("pri_28", 5, 8'h28, 1'b1, 1'b1);
    chk("pri_28_val", uo_out, 8'h05);
    step("pri_00", 5, 8'h00, 1'b1, 1'b1);
    chk("pri_00_err", {7'd0, uio_out[7]}, 8'd1);
    step("pop_f0", 6, 8'hF0, 1'b1, 1'b1);
    chk("pop_f0_val", uo_out, 8'h04);

    step("hold_a5", 0, 8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("hold", 0, 8'h3C, 1'b0, 1'b1);
    chk("hold_val", uo_out, 8'hA5);
    step("hold_rel", 0, 8'h3C, 1'b1, 1'b1);
    chk("hold_rel_val", uo_out, 8'h3C);

    step("mid_a", 6, 8'hFF, 1'b1, 1'b1);
    step("mid_rst", 6, 8'hFF, 1'b0, 1'b0);
    step("mid_rel", 7, 8'h08, 1'b1, 1'b1);

    for (int m = 0; m < 8; m++)
      for (int j = 0; j < 6; j++)
        step("rand", m, int'($urandom_range(0, 255)), 1'b1, 1'b1);
    for (int j = 0; j < 30; j++)
      step("mix", int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
           ($urandom_range(0, 3) != 0), 1'b1);
    step("edge_fe", 3, 8'd100, 1'b1, 1'b1);
    step("edge_99", 3, 8'd99, 1'b1, 1'b1);
    step("edge_4f", 4, 8'h0F, 1'b1, 1'b1);
    step("edge_pri1", 5, 8'h01, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
